// File: rtl/mem_pkg.sv
// Shared definitions for the banked scratch memory: sizing helpers and FSM states.
package mem_pkg;

  // Narrowest legal width for a field that may logically be zero bits wide.
  localparam int MIN_FIELD_W = 1;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Number of low address bits that select the bank.
  function automatic int bank_sel_bits(input int num_banks);
    return clog2(num_banks);
  endfunction

  // Physical width of a field, never below one bit.
  function automatic int field_width(input int bits);
    return (bits > MIN_FIELD_W) ? bits : MIN_FIELD_W;
  endfunction

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mem_bank.sv
// One synchronous single-port bank with registered read.
// Optional byte-strobe writes when MEM_WSTRB_EN is defined.
module mem_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ROW_W      = 6,
  parameter int ROWS       = 64
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [ROW_W-1:0]        row,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [ROWS];

`ifndef MEM_WSTRB_EN
  // Full-word writes only; the strobe port exists for a uniform interface.
  logic unused_wstrb;
  assign unused_wstrb = ^wstrb;
`endif

  // Single port: a write or a registered read of the selected row.
  // NOTE: the array and its read register carry no reset so they map onto
  // RAM macros; contents are cleared by the init sweep in the parent, and the
  // parent gates rdata until a read has actually completed. Non-blocking
  // assignments keep every flop updating from pre-edge values.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
`ifdef MEM_WSTRB_EN
        for (int i = 0; i < DATA_WIDTH/8; i++) begin
          if (wstrb[i]) begin
            mem[row][i*8 +: 8] <= wdata[i*8 +: 8];
          end
        end
`else
        mem[row] <= wdata;
`endif
      end else begin
        rdata <= mem[row];
      end
    end
  end

endmodule

// File: rtl/banked_mem.sv
// Bank-interleaved scratch memory with valid/ready request and response,
// a zero-fill sweep after reset, and a one-entry response stage.
// Optional feature macro: MEM_WSTRB_EN (byte-strobe writes).
module banked_mem
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 8,
  parameter int NUM_BANKS     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic [DATA_WIDTH/8-1:0]  req_wstrb,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     init_done
);

  localparam int BANK_BITS = bank_sel_bits(NUM_BANKS);
  localparam int ROW_BITS  = ADDRESS_WIDTH - BANK_BITS;
  localparam int SEL_W     = field_width(BANK_BITS);
  localparam int ROW_W     = field_width(ROW_BITS);
  localparam int ROWS      = 1 << ROW_BITS;

  state_e                state_q, state_d;
  logic [ROW_W-1:0]      init_cnt;
  logic                  init_last;
  logic [SEL_W-1:0]      req_bank;
  logic [ROW_W-1:0]      req_row;
  logic                  accept;
  logic                  read_accept;
  logic [SEL_W-1:0]      resp_bank;

  logic [NUM_BANKS-1:0]    bank_en;
  logic                    bank_we;
  logic [ROW_W-1:0]        bank_row;
  logic [DATA_WIDTH-1:0]   bank_wdata;
  logic [DATA_WIDTH/8-1:0] bank_wstrb;
  logic [DATA_WIDTH-1:0]   bank_rdata [NUM_BANKS];

  // Address split: low bits pick the bank, the rest pick the row.
  generate
    if (BANK_BITS == 0) begin : g_single_bank
      assign req_bank = '0;
      assign req_row  = req_addr;
    end else if (ROW_BITS == 0) begin : g_single_row
      assign req_bank = req_addr;
      assign req_row  = '0;
    end else begin : g_split
      assign req_bank = req_addr[BANK_BITS-1:0];
      assign req_row  = req_addr[ADDRESS_WIDTH-1:BANK_BITS];
    end
  endgenerate

  assign init_last   = (init_cnt == ROW_W'(ROWS - 1));
  assign accept      = req_valid && req_ready;
  assign read_accept = accept && !req_we;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  // Next state, handshake and bank drive: sweep zeros in INIT, decode in RUN.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    init_done  = 1'b0;
    req_ready  = 1'b0;
    bank_en    = '0;
    bank_we    = 1'b0;
    bank_row   = req_row;
    bank_wdata = req_wdata;
    bank_wstrb = req_wstrb;
    unique case (state_q)
      ST_INIT: begin
        bank_en    = '1;
        bank_we    = 1'b1;
        bank_row   = init_cnt;
        bank_wdata = '0;
        bank_wstrb = '1;
        if (init_last) state_d = ST_RUN;
      end
      ST_RUN: begin
        init_done = 1'b1;
        req_ready = !resp_valid || resp_ready;
        bank_we   = req_we;
        for (int b = 0; b < NUM_BANKS; b++) begin
          bank_en[b] = accept && (req_bank == SEL_W'(b));
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Sweep row counter; returns to zero as the sweep finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_cnt <= '0;
    end else if (state_q == ST_INIT) begin
      init_cnt <= init_last ? '0 : init_cnt + ROW_W'(1);
    end
  end

  // Response stage: set on read accept, held under back-pressure, cleared on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_bank  <= '0;
    end else if (read_accept) begin
      resp_valid <= 1'b1;
      resp_bank  <= req_bank;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  // Read data comes straight from the bank read register of the responding bank.
  always_comb begin
    resp_rdata = '0;
    if (resp_valid) resp_rdata = bank_rdata[resp_bank];
  end

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      mem_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROW_W      (ROW_W),
        .ROWS       (ROWS)
      ) u_bank (
        .clk   (clk),
        .en    (bank_en[b]),
        .we    (bank_we),
        .row   (bank_row),
        .wdata (bank_wdata),
        .wstrb (bank_wstrb),
        .rdata (bank_rdata[b])
      );
    end
  endgenerate

endmodule

// File: tb/tb_banked_mem.sv
// Self-checking bench for banked_mem: reference memory model plus a response scoreboard.
module tb_banked_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        init_done;

  int n_compared = 0;
  int n_mismatched = 0;

  logic [31:0] model [256];
  logic [31:0] sb [$];

  banked_mem dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model[i] = '0;
  endtask

  // Pop and compare each response at the negedge before its handshake edge.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (sb.size() == 0) check("sb_spurious_resp", 32'd1, 32'd0);
      else                check("resp_data", resp_rdata, sb.pop_front());
    end
  end

  // Drive one request and wait (bounded) for acceptance; returns at posedge+1.
  task automatic do_req(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, output int waits);
    waits = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_wstrb = ws;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      waits++;
      if (waits > 50) begin
        check("req_accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
        return;
      end
    end
    if (we) begin
`ifdef MEM_WSTRB_EN
      for (int i = 0; i < 4; i++) if (ws[i]) model[addr][i*8 +: 8] = wd[i*8 +: 8];
`else
      model[addr] = wd;
`endif
    end else begin
      sb.push_back(model[addr]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  // Count edges after reset release until init_done rises.
  task automatic wait_init(output int n);
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      n++;
      if (init_done) return;
      if (n > 200) begin
        check("init_timeout", 32'd0, 32'd1);
        return;
      end
    end
  endtask

  initial begin
    int w;
    int n;
    logic [31:0] exp_strb;

    rst_n = 1'b0;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_wstrb = 4'hF;
    resp_ready = 1'b1;
    clear_model();

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);

    // Zero sweep length and post-sweep readiness.
    rst_n = 1'b1;
    wait_init(n);
    check("init_cycles", n, 32'd64);
    check("init_req_ready", {31'd0, req_ready}, 32'd1);

    // Swept contents read as zero.
    do_req(1'b0, 8'h00, '0, 4'hF, w);
    do_req(1'b0, 8'h7F, '0, 4'hF, w);
    do_req(1'b0, 8'hFF, '0, 4'hF, w);
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Write then read on the next cycle: latency one, new data returned.
    do_req(1'b1, 8'h05, 32'hDEADBEEF, 4'hF, w);
    do_req(1'b0, 8'h05, '0, 4'hF, w);
    idle();
    check("lat_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("lat_resp_rdata", resp_rdata, 32'hDEADBEEF);
    repeat (2) @(posedge clk);
    #1;

    // One write per bank, then back-to-back reads with no bubbles.
    do_req(1'b1, 8'h04, 32'h11111111, 4'hF, w);
    do_req(1'b1, 8'h05, 32'h22222222, 4'hF, w);
    do_req(1'b1, 8'h06, 32'h33333333, 4'hF, w);
    do_req(1'b1, 8'h07, 32'h44444444, 4'hF, w);
    for (int a = 4; a < 8; a++) begin
      do_req(1'b0, 8'(a), '0, 4'hF, w);
      check($sformatf("b2b_wait_%0d", a), w, 32'd0);
      check($sformatf("b2b_valid_%0d", a), {31'd0, resp_valid}, 32'd1);
    end
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Back-pressure: response held, a second read stalls until the pop.
    resp_ready = 1'b0;
    do_req(1'b0, 8'h05, '0, 4'hF, w);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h04;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp_valid_%0d", c), {31'd0, resp_valid}, 32'd1);
      check($sformatf("bp_rdata_%0d", c), resp_rdata, 32'h22222222);
      check($sformatf("bp_req_ready_%0d", c), {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    do_req(1'b0, 8'h04, '0, 4'hF, w);
    check("bp_release_wait", w, 32'd0);
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Partial write under strobes; full-word write otherwise.
    do_req(1'b1, 8'h05, 32'hDEADBEEF, 4'hF, w);
    do_req(1'b1, 8'h05, 32'h000000AA, 4'b0001, w);
    do_req(1'b0, 8'h05, '0, 4'hF, w);
    idle();
`ifdef MEM_WSTRB_EN
    exp_strb = 32'hDEADBEAA;
`else
    exp_strb = 32'h000000AA;
`endif
    check("wstrb_rdata", resp_rdata, exp_strb);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-stream with a response pending.
    resp_ready = 1'b0;
    do_req(1'b0, 8'h05, '0, 4'hF, w);
    idle();
    check("mid_pre_valid", {31'd0, resp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_init_done", {31'd0, init_done}, 32'd0);
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    sb.delete();
    clear_model();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init(n);
    check("reinit_cycles", n, 32'd64);
    do_req(1'b0, 8'h05, '0, 4'hF, w);
    idle();
    check("reinit_rdata", resp_rdata, 32'd0);
    repeat (3) @(posedge clk);
    #1;

    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
